// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: packs instruction field bundles into MIPS words and streams them to imem.
// Optional field legality checking enabled by defining MIPS_ENC_FIELD_CHECK_EN.
`default_nettype none

module mips_instr_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0040_0000),
    parameter int                DEPTH     = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_kind,
    input  logic [4:0]                 in_rs,
    input  logic [4:0]                 in_rt,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_shamt,
    input  logic [5:0]                 in_funct,
    input  logic [15:0]                in_imm,
    input  logic                       in_last,
    output logic                       wr_valid,
    input  logic                       wr_ready,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [31:0]                wr_data,
    output logic [$clog2(DEPTH+1)-1:0] word_cnt,
    output logic                       busy,
    output logic                       done,
    output logic                       full,
    output logic                       err
);

    localparam int             CNT_W   = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    localparam logic [1:0] C_K_R    = 2'd0;
    localparam logic [1:0] C_K_ADDI = 2'd1;
    localparam logic [1:0] C_K_ORI  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_wr_valid;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [31:0]        r_wr_data;
    logic [CNT_W-1:0]   r_word_cnt;
    logic               r_full;
    logic               r_err;

    logic               w_accept;
    logic               w_wr_done;
    logic               w_legal;
    logic               w_end_session;
    logic [31:0]        w_word;

    assign w_wr_done     = r_wr_valid & wr_ready;
    assign in_ready      = (r_state == S_RUN) && (!r_wr_valid || wr_ready);
    assign w_accept      = in_valid & in_ready;
    assign w_end_session = in_last || (r_word_cnt == C_DEPTH - CNT_W'(1));

    always_comb begin
        w_word = 32'h0;
        case (in_kind)
            C_K_R:    w_word = {6'h00, in_rs, in_rt, in_rd, in_shamt, in_funct};
            C_K_ADDI: w_word = {6'h08, in_rs, in_rt, in_imm};
            C_K_ORI:  w_word = {6'h0D, in_rs, in_rt, in_imm};
            default:  w_word = {6'h0F, 5'b0, in_rt, in_imm};
        endcase
    end

`ifdef MIPS_ENC_FIELD_CHECK_EN
    logic w_funct_ok;
    logic w_is_shift;

    always_comb begin
        w_funct_ok = 1'b0;
        w_is_shift = 1'b0;
        case (in_funct)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h27: w_funct_ok = 1'b1;
            6'h00, 6'h02: begin
                w_funct_ok = 1'b1;
                w_is_shift = 1'b1;
            end
            default: w_funct_ok = 1'b0;
        endcase

        w_legal = 1'b1;
        if (in_kind == C_K_R) begin
            // Shifts take their operand from rt, so rs must be zero; other ALU ops leave shamt unused.
            w_legal = w_funct_ok && (in_rd != 5'd0) &&
                      (w_is_shift ? (in_rs == 5'd0) : (in_shamt == 5'd0));
        end else begin
            w_legal = (in_rt != 5'd0);
        end
    end
`else
    assign w_legal = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= BASE_ADDR;
            r_wr_data  <= 32'h0;
            r_word_cnt <= '0;
            r_full     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_word_cnt <= '0;
                        r_full     <= 1'b0;
                        r_err      <= 1'b0;
                        r_wr_addr  <= BASE_ADDR;
                    end
                end
                S_RUN: begin
                    if (w_wr_done) begin
                        r_wr_valid <= 1'b0;
                        r_wr_addr  <= r_wr_addr + ADDR_W'(4);
                    end
                    // A new accept overrides the drain above so the output reg reloads without a bubble.
                    if (w_accept) begin
                        if (r_word_cnt != C_DEPTH) begin
                            r_word_cnt <= r_word_cnt + CNT_W'(1);
                        end
                        if (w_legal) begin
                            r_wr_valid <= 1'b1;
                            r_wr_data  <= w_word;
                        end else begin
                            r_err <= 1'b1;
                        end
                        if (w_end_session) begin
                            r_state <= S_FLUSH;
                            r_full  <= !in_last;
                        end
                    end
                end
                S_FLUSH: begin
                    if (!r_wr_valid || wr_ready) begin
                        if (r_wr_valid) begin
                            r_wr_addr <= r_wr_addr + ADDR_W'(4);
                        end
                        r_wr_valid <= 1'b0;
                        r_state    <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign word_cnt = r_word_cnt;
    assign busy     = (r_state == S_RUN) || (r_state == S_FLUSH);
    assign done     = (r_state == S_DONE);
    assign full     = r_full;
    assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder: directed self-checking bench; a second instance with DEPTH=4 covers the depth limit.
`default_nettype none

module tb_mips_instr_encoder;

    localparam logic [31:0] C_BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_kind = 2'd0;
    logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0, in_shamt = 5'd0;
    logic [5:0]  in_funct = 6'd0;
    logic [15:0] in_imm = 16'd0;
    logic        in_last = 1'b0;
    logic        wr_ready = 1'b0;

    logic        in_ready, wr_valid, busy, done, full, err;
    logic [31:0] wr_addr, wr_data;
    logic [6:0]  word_cnt;

    logic        in_ready4, wr_valid4, busy4, done4, full4, err4;
    logic [31:0] wr_addr4, wr_data4;
    logic [2:0]  word_cnt4;

    int checks = 0;
    int failures = 0;
    logic sel = 1'b0;
    logic [31:0] q_addr[$], q_data[$], q4_addr[$], q4_data[$];

    always #5 clk = ~clk;

    mips_instr_encoder u_dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_last(in_last), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .word_cnt(word_cnt),
        .busy(busy), .done(done), .full(full), .err(err)
    );

    mips_instr_encoder #(.DEPTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready4),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_last(in_last), .wr_valid(wr_valid4),
        .wr_ready(wr_ready), .wr_addr(wr_addr4), .wr_data(wr_data4), .word_cnt(word_cnt4),
        .busy(busy4), .done(done4), .full(full4), .err(err4)
    );

    // Completed writes are logged mid-cycle, when both handshake sides are stable.
    always @(negedge clk) begin
        if (wr_valid && wr_ready) begin
            q_addr.push_back(wr_addr);
            q_data.push_back(wr_data);
        end
        if (wr_valid4 && wr_ready) begin
            q4_addr.push_back(wr_addr4);
            q4_data.push_back(wr_data4);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        step;
        reset = 1'b0;
        step;
        q_addr.delete(); q_data.delete(); q4_addr.delete(); q4_data.delete();
    endtask

    task automatic do_start;
        start = 1'b1;
        step;
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [15:0] imm, input logic last);
        logic ok;
        ok = 1'b0;
        in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_funct = fn; in_imm = imm; in_last = last; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sel ? in_ready4 : in_ready) begin
                step;
                ok = 1'b1;
                break;
            end
            step;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout: accepted=%0d required=1", ok);
        end
    endtask

    task automatic test_reset_mid_flush;
        do_reset;
        wr_ready = 1'b0;
        do_start;
        send(2'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 1'b1);
        step;
        checks++;
        if (wr_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL t1_pre_flush: wr_valid=%b busy=%b required 1 1", wr_valid, busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (wr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 ||
            full !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL t1_reset_flags: wr_valid=%b busy=%b done=%b in_ready=%b full=%b err=%b required all 0",
                     wr_valid, busy, done, in_ready, full, err);
        end
        checks++;
        if (word_cnt !== 7'd0 || wr_addr !== C_BASE || wr_data !== 32'h0) begin
            failures++;
            $display("FAIL t1_reset_regs: cnt=%0d addr=%h data=%h required 0 %h 0", word_cnt, wr_addr, wr_data, C_BASE);
        end
        step;
        reset = 1'b0;
        step;
    endtask

    task automatic test_single_addi;
        do_reset;
        wr_ready = 1'b1;
        do_start;
        send(2'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 1'b1);
        checks++;
        if (wr_valid !== 1'b1 || wr_data !== 32'h2008_0005 || wr_addr !== C_BASE) begin
            failures++;
            $display("FAIL t2_word: valid=%b data=%h addr=%h required 1 20080005 %h", wr_valid, wr_data, wr_addr, C_BASE);
        end
        step;
        checks++;
        if (done !== 1'b1 || word_cnt !== 7'd1 || wr_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL t2_done: done=%b cnt=%0d valid=%b busy=%b required 1 1 0 0", done, word_cnt, wr_valid, busy);
        end
        checks++;
        if (q_data.size() != 1) begin
            failures++;
            $display("FAIL t2_count: writes=%0d required 1", q_data.size());
        end
    endtask

    task automatic test_program;
        logic [31:0] exp_d [3];
        exp_d[0] = 32'h0109_5020;
        exp_d[1] = 32'h3C01_1001;
        exp_d[2] = 32'h3421_0024;
        q_addr.delete(); q_data.delete();
        wr_ready = 1'b1;
        do_start;
        checks++;
        if (busy !== 1'b1 || word_cnt !== 7'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL t3_restart: busy=%b cnt=%0d in_ready=%b required 1 0 1", busy, word_cnt, in_ready);
        end
        send(2'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0, 1'b0);
        send(2'd3, 5'd7, 5'd1, 5'd0, 5'd0, 6'h0, 16'h1001, 1'b0);
        send(2'd2, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0024, 1'b1);
        step;
        checks++;
        if (q_data.size() != 3) begin
            failures++;
            $display("FAIL t3_count: writes=%0d required 3", q_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (q_data[i] !== exp_d[i] || q_addr[i] !== C_BASE + 32'(4 * i)) begin
                    failures++;
                    $display("FAIL t3_word%0d: data=%h addr=%h required %h %h", i, q_data[i], q_addr[i],
                             exp_d[i], C_BASE + 32'(4 * i));
                end
            end
        end
        checks++;
        if (done !== 1'b1 || word_cnt !== 7'd3 || wr_addr !== C_BASE + 32'd12) begin
            failures++;
            $display("FAIL t3_done: done=%b cnt=%0d addr=%h required 1 3 0040000c", done, word_cnt, wr_addr);
        end
    endtask

    task automatic test_backpressure;
        do_reset;
        wr_ready = 1'b0;
        do_start;
        send(2'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 1'b0);
        in_kind = 2'd2; in_rs = 5'd2; in_rt = 5'd3; in_imm = 16'h00AB; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (in_ready !== 1'b0 || wr_valid !== 1'b1 || wr_data !== 32'h0022_1820 || wr_addr !== C_BASE) begin
                failures++;
                $display("FAIL t4_stall%0d: in_ready=%b valid=%b data=%h addr=%h required 0 1 00221820 %h",
                         i, in_ready, wr_valid, wr_data, wr_addr, C_BASE);
            end
            step;
        end
        wr_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL t4_resume_ready: in_ready=%b required 1", in_ready);
        end
        step;
        in_valid = 1'b0;
        in_last = 1'b0;
        checks++;
        if (wr_valid !== 1'b1 || wr_data !== 32'h3443_00AB || wr_addr !== C_BASE + 32'd4) begin
            failures++;
            $display("FAIL t4_second: valid=%b data=%h addr=%h required 1 344300ab 00400004", wr_valid, wr_data, wr_addr);
        end
        step;
        checks++;
        if (q_data.size() != 2 || done !== 1'b1) begin
            failures++;
            $display("FAIL t4_count: writes=%0d done=%b required 2 1", q_data.size(), done);
        end else begin
            checks++;
            if (q_data[0] !== 32'h0022_1820 || q_data[1] !== 32'h3443_00AB || q_addr[1] !== C_BASE + 32'd4) begin
                failures++;
                $display("FAIL t4_words: d0=%h d1=%h a1=%h required 00221820 344300ab 00400004",
                         q_data[0], q_data[1], q_addr[1]);
            end
        end
    endtask

    task automatic test_depth_limit;
        int n;
        sel = 1'b1;
        do_reset;
        wr_ready = 1'b1;
        do_start;
        n = 0;
        in_kind = 2'd1; in_rs = 5'd0; in_rt = 5'd1; in_last = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = (n < 6);
            in_imm = 16'(n);
            if (in_valid && in_ready4) n++;
            step;
        end
        in_valid = 1'b1;
        #1;
        checks++;
        if (n != 4 || q4_data.size() != 4) begin
            failures++;
            $display("FAIL t5_count: accepts=%0d writes=%0d required 4 4", n, q4_data.size());
        end else begin
            checks++;
            if (q4_addr[3] !== 32'h0040_000C || q4_data[3] !== 32'h2001_0003) begin
                failures++;
                $display("FAIL t5_last: addr=%h data=%h required 0040000c 20010003", q4_addr[3], q4_data[3]);
            end
        end
        checks++;
        if (full4 !== 1'b1 || done4 !== 1'b1 || in_ready4 !== 1'b0 || word_cnt4 !== 3'd4) begin
            failures++;
            $display("FAIL t5_flags: full=%b done=%b in_ready=%b cnt=%0d required 1 1 0 4",
                     full4, done4, in_ready4, word_cnt4);
        end
        in_valid = 1'b0;
        do_reset;
        do_start;
        for (int i = 0; i < 4; i++) begin
            send(2'd1, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'(i), (i == 3));
        end
        step;
        checks++;
        if (full4 !== 1'b0 || done4 !== 1'b1 || word_cnt4 !== 3'd4 || q4_data.size() != 4) begin
            failures++;
            $display("FAIL t5_last_on_depth: full=%b done=%b cnt=%0d writes=%0d required 0 1 4 4",
                     full4, done4, word_cnt4, q4_data.size());
        end
        sel = 1'b0;
    endtask

    task automatic test_field_check;
        do_reset;
        wr_ready = 1'b1;
        do_start;
        send(2'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h3F, 16'h0, 1'b0);
        send(2'd2, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0024, 1'b1);
        step;
`ifdef MIPS_ENC_FIELD_CHECK_EN
        checks++;
        if (err !== 1'b1 || word_cnt !== 7'd2 || q_data.size() != 1) begin
            failures++;
            $display("FAIL t6_drop: err=%b cnt=%0d writes=%0d required 1 2 1", err, word_cnt, q_data.size());
        end else begin
            checks++;
            if (q_data[0] !== 32'h3421_0024 || q_addr[0] !== C_BASE) begin
                failures++;
                $display("FAIL t6_word: data=%h addr=%h required 34210024 %h", q_data[0], q_addr[0], C_BASE);
            end
        end
        do_start;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL t6_err_clear: err=%b required 0", err);
        end
`else
        checks++;
        if (err !== 1'b0 || word_cnt !== 7'd2 || q_data.size() != 2) begin
            failures++;
            $display("FAIL t6_verbatim: err=%b cnt=%0d writes=%0d required 0 2 2", err, word_cnt, q_data.size());
        end else begin
            checks++;
            if (q_data[0] !== 32'h0022_183F || q_data[1] !== 32'h3421_0024 || q_addr[1] !== C_BASE + 32'd4) begin
                failures++;
                $display("FAIL t6_words: d0=%h d1=%h a1=%h required 0022183f 34210024 00400004",
                         q_data[0], q_data[1], q_addr[1]);
            end
        end
`endif
    endtask

    initial begin
        test_reset_mid_flush;
        test_single_addi;
        test_program;
        test_backpressure;
        test_depth_limit;
        test_field_check;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
